bbs_word_packer: RTL and testbench
==================================

Name: bbs_word_packer

Overview:
- Consumer end of the BBS generator's bit stream.
- Issues one-cycle start requests to the generator and captures each produced bit when the generator signals completion.
- Packs bits into W-bit words and offers them downstream through a 2-entry output FIFO with valid/ready handshake.
- Throttles requests so a completed word never meets a full FIFO.

Parameters:
- W, 16, output word width in bits (W >= 2).
- CW, $clog2(W+1), width of the internal bit counter (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  level; when 1 the block keeps requesting bits.
- gen_start  output  1  one-cycle pulse requesting the next generator iteration.
- bit_valid  input  1  one-cycle pulse from the generator; b_i is valid in that cycle.
- b_i  input  1  generator output bit (LSB of x_{i+1}).
- word_out  output  W  head-of-FIFO word.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  downstream accepts word_out when word_valid && word_ready.
- fill  output  2  FIFO occupancy, 0..2.
- bit_cnt  output  CW  bits held in the partial word, 0..W-1.
- err_unsolicited  output  1  sticky; a bit_valid arrived outside WAIT.

Behaviour:
- Reset (async, any state, mid-operation included): state=IDLE; gen_start=0, word_valid=0, word_out=0, fill=0, bit_cnt=0, err_unsolicited=0; shift register and FIFO contents cleared.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when enable=1 and room=1.
  - room = (bit_cnt != W-1) || (fill < 2), evaluated with the current-cycle fill, before that cycle's pop.
  - REQ: gen_start=1 for exactly this cycle, then -> WAIT unconditionally.
  - WAIT: gen_start=0; hold until bit_valid=1.
  - On bit_valid in WAIT: shift = {shift[W-2:0], b_i}, so the first bit of a word ends in bit W-1. bit_cnt increments.
  - If that bit completes the word (bit_cnt was W-1): push the full word into the FIFO and set bit_cnt=0.
  - After capture, next state is REQ if enable && room (room evaluated after this capture and push), else IDLE.
  - No gen_start is issued in the cycle bit_valid is seen; minimum request spacing is 2 cycles.
- enable deasserted while in WAIT: the outstanding bit is still awaited and captured, then -> IDLE. The partial word is retained, and packing resumes on re-enable.
- bit_valid in IDLE or REQ: bit is dropped, err_unsolicited set to 1. It is cleared only by rst.
- FIFO:
  - First-word fall-through: word_out is the oldest entry the cycle after its push.
  - Pop on word_valid && word_ready.
  - Simultaneous push and pop: at fill=1, fill stays 1 and order is preserved. At fill=2, the push cannot occur because room gating guarantees it.
  - Pop at fill=0 is ignored.
  - word_out holds its value while word_valid=0 (last popped or 0 after reset).
- Latency: a word becomes visible on word_valid 1 cycle after the bit_valid that completes it.

Optional Feature:
- Macro: BBS_VON_NEUMANN_EN.
- Defined: bits are consumed in pairs (first, second) from consecutive bit_valid events.
  - Pair 10 shifts in 1; pair 01 shifts in 0; pairs 00 and 11 are discarded.
  - An internal half flag marks a held first bit. It is cleared by rst; enable deassert does not clear it.
  - The room rule is unchanged; bit_cnt counts only accepted, debiased bits.
- Undefined: every bit is packed raw; no pair logic is synthesized.

Test Plan:
- Reset with W=8; enable=1; generator model returns bit_valid 3 cycles after each gen_start with bits 1,0,1,1,0,0,1,0 -> exactly one word 8'hB2 on word_valid; fill=1; 8 gen_start pulses.
- word_ready=0 while generator streams 3 words 8'hFF, 8'h00, 8'hA5 -> fill reaches 2. bit_cnt stops at 7 with no gen_start. Raise word_ready for one cycle -> 8'hFF popped, request resumes, 8'hA5 later appears at tail.
- Drop enable while in WAIT after 4 bits -> 5th bit captured, bit_cnt=5, state IDLE, no further gen_start. Re-enable -> 3 more bits complete the word.
- Pulse bit_valid while in IDLE -> err_unsolicited=1, bit_cnt unchanged; stays 1 until rst.
- Assert rst mid-WAIT with fill=1, bit_cnt=3 -> all outputs immediately 0; a late bit_valid after release sets err_unsolicited.
- With BBS_VON_NEUMANN_EN: bits 1,0, 1,1, 0,1, 0,0 -> accepted 1,0; bit_cnt=2.

Source files
------------

// File: rtl/bbs_word_packer.sv
// Consumer end of the BBS bit stream: requests bits, packs them MSB-first into W-bit words
// and queues them in a 2-entry fall-through FIFO. Optional debiasing: BBS_VON_NEUMANN_EN.
module bbs_word_packer #(
    parameter int W = 16,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          gen_start,
    input  logic          bit_valid,
    input  logic          b_i,
    output logic [W-1:0]  word_out,
    output logic          word_valid,
    input  logic          word_ready,
    output logic [1:0]    fill,
    output logic [CW-1:0] bit_cnt,
    output logic          err_unsolicited
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state, next_state;
    logic [W-2:0]  shift;
    logic [W-1:0]  new_word;
    logic [W-1:0]  mem0, mem1;
    logic          capture, accept, acc_bit, complete, push, pop;
    logic [CW-1:0] cnt_next;
    logic [2:0]    fill_pushed;
    logic          room_now, room_after;

    assign capture = (state == WAIT) && bit_valid;

`ifdef BBS_VON_NEUMANN_EN
    logic half, first;

    // A pair emits its first bit only when the two bits differ (10 -> 1, 01 -> 0).
    assign accept  = capture && half && (first != b_i);
    assign acc_bit = first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half  <= 1'b0;
            first <= 1'b0;
        end else if (capture) begin
            half <= ~half;
            if (!half) first <= b_i;
        end
    end
`else
    assign accept  = capture;
    assign acc_bit = b_i;
`endif

    assign new_word    = {shift, acc_bit};
    assign complete    = accept && (bit_cnt == LAST);
    assign push        = complete;
    assign pop         = word_valid && word_ready;
    assign cnt_next    = complete ? '0 : (accept ? bit_cnt + CW'(1) : bit_cnt);
    assign fill_pushed = {1'b0, fill} + {2'b00, push};

    // Never request the bit that would complete a word while the FIFO is full.
    assign room_now   = (bit_cnt != LAST) || (fill < 2'd2);
    assign room_after = (cnt_next != LAST) || (fill_pushed < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        gen_start  = 1'b0;
        case (state)
            IDLE: if (enable && room_now) next_state = REQ;
            REQ: begin
                gen_start  = 1'b1;
                next_state = WAIT;
            end
            WAIT: if (bit_valid) next_state = (enable && room_after) ? REQ : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift           <= '0;
            bit_cnt         <= '0;
            err_unsolicited <= 1'b0;
        end else begin
            if (bit_valid && (state != WAIT)) err_unsolicited <= 1'b1;
            if (accept) begin
                shift   <= new_word[W-2:0];
                bit_cnt <= cnt_next;
            end
        end
    end

    // mem0 is always the head; it keeps the last popped word once the FIFO drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0 <= '0;
            mem1 <= '0;
            fill <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fill == 2'd0) mem0 <= new_word;
                    else              mem1 <= new_word;
                    fill <= fill + 2'd1;
                end
                2'b01: begin
                    if (fill == 2'd2) mem0 <= mem1;
                    fill <= fill - 2'd1;
                end
                2'b11: begin
                    if (fill == 2'd1) begin
                        mem0 <= new_word;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= new_word;
                    end
                end
                default: ;
            endcase
        end
    end

    assign word_out   = mem0;
    assign word_valid = (fill != 2'd0);

endmodule

// File: tb/tb_bbs_word_packer.sv
// Bench for bbs_word_packer: a generator model answers gen_start, and a queue-based model
// of bit packing and the output FIFO predicts every output each cycle.
module tb_bbs_word_packer;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          gen_start;
    logic          bit_valid = 1'b0;
    logic          b_i = 1'b0;
    logic [W-1:0]  word_out;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic [1:0]    fill;
    logic [CW-1:0] bit_cnt;
    logic          err_unsolicited;

    bbs_word_packer #(.W(W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .gen_start(gen_start),
        .bit_valid(bit_valid), .b_i(b_i), .word_out(word_out),
        .word_valid(word_valid), .word_ready(word_ready), .fill(fill),
        .bit_cnt(bit_cnt), .err_unsolicited(err_unsolicited)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit en_drv = 1'b0, rdy_drv = 1'b0, inject_unsol = 1'b0;
    bit outstanding = 1'b0, stale = 1'b0, next_bit = 1'b0, fixed_delay = 1'b1;
    int countdown = 0, gen_count = 0, stall = 0;
    bit bit_src[$];

    logic [W-1:0] m_word, m_last;
    logic [W-1:0] m_fifo[$];
    int m_cnt;
    bit m_err, m_half, m_first;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit m_room();
        return (m_cnt != W - 1) || (m_fifo.size() < 2);
    endfunction

    task automatic modelReset();
        m_word = '0; m_last = '0; m_cnt = 0; m_err = 1'b0;
        m_half = 1'b0; m_first = 1'b0;
        m_fifo.delete();
    endtask

    // Spec-level packing: optional pair debiasing, then MSB-first accumulation.
    task automatic modelBit(input bit b);
        bit v;
        v = b;
`ifdef BBS_VON_NEUMANN_EN
        if (!m_half) begin
            m_half = 1'b1;
            m_first = b;
            return;
        end
        m_half = 1'b0;
        if (m_first == b) return;
        v = m_first;
`endif
        m_word = (m_word << 1) | W'(v);
        m_cnt++;
        if (m_cnt == W) begin
            m_fifo.push_back(m_word);
            m_cnt = 0;
        end
    endtask

    // One clock cycle: drive inputs, predict, clock, compare, then let the generator react.
    task automatic applyStimulus();
        bit fire, gs, pop;
        fire = outstanding && (countdown == 1);
        enable = en_drv;
        word_ready = rdy_drv;
        bit_valid = fire || inject_unsol;
        b_i = fire ? next_bit : 1'($urandom_range(0, 1));
        gs = gen_start;
        checkOutput("req_while_busy", 32'(gs && outstanding), 32'd0);
        checkOutput("req_without_room", 32'(gs && !m_room()), 32'd0);
        if (en_drv && !outstanding && m_room() && !gs) stall++;
        else stall = 0;
        checkOutput("request_stall", 32'(stall > 2), 32'd0);

        pop = (m_fifo.size() > 0) && rdy_drv;
        if (pop) m_last = m_fifo.pop_front();
        if (inject_unsol || (fire && stale)) m_err = 1'b1;
        if (fire && !stale) modelBit(next_bit);

        @(posedge clk);
        #1;
        checkOutput("fill", 32'(fill), 32'(m_fifo.size()));
        checkOutput("word_valid", 32'(word_valid), 32'(m_fifo.size() != 0));
        checkOutput("word_out", 32'(word_out), 32'(m_fifo.size() != 0 ? m_fifo[0] : m_last));
        checkOutput("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
        checkOutput("err_unsolicited", 32'(err_unsolicited), 32'(m_err));

        if (fire) begin
            outstanding = 1'b0;
            stale = 1'b0;
        end else if (outstanding) begin
            countdown--;
        end
        if (gs) begin
            outstanding = 1'b1;
            gen_count++;
            countdown = fixed_delay ? 3 : $urandom_range(1, 4);
            next_bit = (bit_src.size() != 0) ? bit_src.pop_front() : 1'($urandom_range(0, 1));
        end
        inject_unsol = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic doReset(input bit keep_pending);
        rst = 1'b1;
        enable = 1'b0;
        bit_valid = 1'b0;
        inject_unsol = 1'b0;
        #1;
        checkOutput("rst_gen_start", 32'(gen_start), 32'd0);
        checkOutput("rst_word_valid", 32'(word_valid), 32'd0);
        checkOutput("rst_word_out", 32'(word_out), 32'd0);
        checkOutput("rst_fill", 32'(fill), 32'd0);
        checkOutput("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        checkOutput("rst_err", 32'(err_unsolicited), 32'd0);
        stale = keep_pending && outstanding;
        if (!stale) outstanding = 1'b0;
        modelReset();
        stall = 0;
        gen_count = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pushBits(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) bit_src.push_back(w[i]);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int budget;
        int saved_cnt;
        modelReset();
        doReset(1'b0);

`ifndef BBS_VON_NEUMANN_EN
        // First word: 1,0,1,1,0,0,1,0 packs to B2.
        pushBits(8'hB2);
        en_drv = 1'b1;
        rdy_drv = 1'b0;
        budget = 200;
        while (m_fifo.size() == 0 && budget > 0) begin applyStimulus(); budget--; end
        checkOutput("t1_timeout", 32'(budget == 0), 32'd0);
        checkOutput("t1_word", 32'(word_out), 32'h0000_00B2);
        checkOutput("t1_fill", 32'(fill), 32'd1);
        checkOutput("t1_gen_count", 32'(gen_count), 32'd8);

        // Back-pressure: FF and 00 fill the FIFO, A5 stalls at 7 bits.
        doReset(1'b0);
        bit_src.delete();
        pushBits(8'hFF); pushBits(8'h00); pushBits(8'hA5);
        en_drv = 1'b1;
        rdy_drv = 1'b0;
        budget = 400;
        while (!(m_cnt == 7 && m_fifo.size() == 2) && budget > 0) begin applyStimulus(); budget--; end
        checkOutput("t2_timeout", 32'(budget == 0), 32'd0);
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("t2_gen_held", 32'(gen_count), 32'd23);
        checkOutput("t2_fill_full", 32'(fill), 32'd2);
        checkOutput("t2_bit_cnt", 32'(bit_cnt), 32'd7);
        checkOutput("t2_head_ff", 32'(word_out), 32'h0000_00FF);
        rdy_drv = 1'b1;
        applyStimulus();
        rdy_drv = 1'b0;
        checkOutput("t2_head_00", 32'(word_out), 32'h0000_0000);
        checkOutput("t2_fill_after_pop", 32'(fill), 32'd1);
        budget = 100;
        while (m_fifo.size() != 2 && budget > 0) begin applyStimulus(); budget--; end
        checkOutput("t2_resume_timeout", 32'(budget == 0), 32'd0);
        rdy_drv = 1'b1;
        applyStimulus();
        rdy_drv = 1'b0;
        checkOutput("t2_tail_a5", 32'(word_out), 32'h0000_00A5);

        // Disable while waiting on the 5th bit; the partial word survives re-enable.
        doReset(1'b0);
        bit_src.delete();
        pushBits(8'hCA);
        en_drv = 1'b1;
        budget = 200;
        while (gen_count < 5 && budget > 0) begin applyStimulus(); budget--; end
        en_drv = 1'b0;
        while (outstanding && budget > 0) begin applyStimulus(); budget--; end
        checkOutput("t3_timeout", 32'(budget == 0), 32'd0);
        checkOutput("t3_bit_cnt", 32'(bit_cnt), 32'd5);
        for (int i = 0; i < 8; i++) applyStimulus();
        checkOutput("t3_no_request", 32'(gen_count), 32'd5);
        en_drv = 1'b1;
        budget = 100;
        while (m_fifo.size() == 0 && budget > 0) begin applyStimulus(); budget--; end
        checkOutput("t3_resume_timeout", 32'(budget == 0), 32'd0);
        checkOutput("t3_word", 32'(word_out), 32'h0000_00CA);
        checkOutput("t3_gen_count", 32'(gen_count), 32'd8);

        // Unsolicited bit while idle.
        en_drv = 1'b0;
        budget = 50;
        do begin applyStimulus(); budget--; end while (outstanding && budget > 0);
        for (int i = 0; i < 3; i++) applyStimulus();
        saved_cnt = m_cnt;
        inject_unsol = 1'b1;
        applyStimulus();
        checkOutput("t4_err_set", 32'(err_unsolicited), 32'd1);
        checkOutput("t4_bit_cnt_kept", 32'(bit_cnt), 32'(saved_cnt));
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("t4_err_sticky", 32'(err_unsolicited), 32'd1);

        // Reset mid-WAIT with one word queued and 3 bits held; the late bit is unsolicited.
        doReset(1'b0);
        bit_src.delete();
        en_drv = 1'b1;
        budget = 300;
        while (!(m_fifo.size() == 1 && m_cnt == 3 && outstanding) && budget > 0) begin
            applyStimulus();
            budget--;
        end
        checkOutput("t5_timeout", 32'(budget == 0), 32'd0);
        checkOutput("t5_pre_fill", 32'(fill), 32'd1);
        en_drv = 1'b0;
        doReset(1'b1);
        budget = 20;
        while (outstanding && budget > 0) begin applyStimulus(); budget--; end
        checkOutput("t5_late_err", 32'(err_unsolicited), 32'd1);
        checkOutput("t5_bit_cnt", 32'(bit_cnt), 32'd0);
`else
        // Debiasing: pairs 10,11,01,00 yield accepted bits 1,0.
        bit_src = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        en_drv = 1'b1;
        budget = 200;
        while (gen_count < 8 && budget > 0) begin applyStimulus(); budget--; end
        en_drv = 1'b0;
        while (outstanding && budget > 0) begin applyStimulus(); budget--; end
        checkOutput("vn_timeout", 32'(budget == 0), 32'd0);
        checkOutput("vn_bit_cnt", 32'(bit_cnt), 32'd2);
        checkOutput("vn_fill", 32'(fill), 32'd0);
`endif

        // Random traffic: random delays, enable toggles, alternating ready pressure.
        doReset(1'b0);
        bit_src.delete();
        fixed_delay = 1'b0;
        en_drv = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) en_drv = !en_drv;
            if (((i / 300) % 2) == 1) rdy_drv = ($urandom_range(0, 3) == 0);
            else                      rdy_drv = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
